seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver with per-slot dead time and per-frame digit snapshot.
// Optional leading-zero blanking is enabled with the SEG7_LEADING_ZERO_BLANK_EN macro.
module seg7_scan_driver #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_u,
    input  logic [3:0] bcd_d,
    input  logic [3:0] bcd_c,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int unsigned   CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    snap_u_q, snap_u_d;
    logic [3:0]    snap_d_q, snap_d_d;
    logic [3:0]    snap_c_q, snap_c_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          done_q, done_d;

    logic          frame_end;
    logic [3:0]    digit;
    logic [2:0]    onehot;
    logic          digit_blank;
    logic          show;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b1001111;
        endcase
        return s;
    endfunction

    // Outputs are registered from the next-state values so they line up with (idx, cnt).
    always_comb begin
        frame_end = (idx_q == 2'd2) && (cnt_q == CNT_MAX);

        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        snap_u_d = snap_u_q;
        snap_d_d = snap_d_q;
        snap_c_d = snap_c_q;
        if (frame_end) begin
            snap_u_d = bcd_u;
            snap_d_d = bcd_d;
            snap_c_d = bcd_c;
        end

        case (idx_d)
            2'd0: begin
                digit  = snap_u_d;
                onehot = 3'b001;
            end
            2'd1: begin
                digit  = snap_d_d;
                onehot = 3'b010;
            end
            2'd2: begin
                digit  = snap_c_d;
                onehot = 3'b100;
            end
            default: begin
                digit  = snap_u_d;
                onehot = 3'b000;
            end
        endcase

        digit_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx_d == 2'd2 && snap_c_d == 4'd0)
            digit_blank = 1'b1;
        if (idx_d == 2'd1 && snap_c_d == 4'd0 && snap_d_d == 4'd0)
            digit_blank = 1'b1;
`else
        digit_blank = 1'b0;
`endif

        show   = (cnt_d >= BLANK_END) && !digit_blank;
        seg_d  = show ? decode(digit) : '0;
        an_d   = show ? onehot : '0;
        done_d = (idx_d == 2'd2) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            snap_u_q <= '0;
            snap_d_q <= '0;
            snap_c_q <= '0;
            seg_q    <= '0;
            an_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            snap_u_q <= snap_u_d;
            snap_d_q <= snap_d_d;
            snap_c_q <= snap_c_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            done_q   <= done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random digit streams
// compared against a frame/slot arithmetic model of the display.
module tb_seg7_scan_driver;

    localparam int P = 4;
    localparam int B = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bu = '0, bd = '0, bc = '0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       fd;

    int checks = 0;
    int errors = 0;
    int t = 0;
    logic [3:0] shown [3];
    logic [6:0] font [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .PRESCALE    (P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_u     (bu),
        .bcd_d     (bd),
        .bcd_c     (bc),
        .seg       (seg),
        .an        (an),
        .frame_done(fd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // Expected {an, seg} for cycle number cyc of the current run.
    function automatic logic [9:0] expect_out(input int cyc);
        int   slot;
        int   pos;
        logic blank;
        slot  = (cyc / P) % 3;
        pos   = cyc % P;
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot == 2 && shown[2] == 0) blank = 1'b1;
        if (slot == 1 && shown[2] == 0 && shown[1] == 0) blank = 1'b1;
`endif
        if (pos < B || blank) return '0;
        return {3'(1 << slot), font[shown[slot]]};
    endfunction

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 3) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic cycle(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
        logic [9:0] e;
        logic       last;
        @(negedge clk);
        e    = expect_out(t);
        last = ((t / P) % 3 == 2) && (t % P == P - 1);
        check("an", an, e[9:7]);
        check("seg", seg, e[6:0]);
        check("frame_done", fd, last);
        bu = u;
        bd = d;
        bc = c;
        if (last) begin
            shown[0] = u;
            shown[1] = d;
            shown[2] = c;
        end
        t++;
    endtask

    task automatic restart();
        @(posedge clk);
        #1 rst = 1'b0;
        t = 0;
        for (int i = 0; i < 3; i++) shown[i] = '0;
    endtask

    initial begin
        logic [3:0] u, d, c;

        font[0] = 7'b1111110; font[1] = 7'b0110000; font[2] = 7'b1101101;
        font[3] = 7'b1111001; font[4] = 7'b0110011; font[5] = 7'b1011011;
        font[6] = 7'b1011111; font[7] = 7'b1110000; font[8] = 7'b1111111;
        font[9] = 7'b1111011;
        for (int i = 10; i < 16; i++) font[i] = 7'b1001111;

        // Reset state while rst is held
        @(negedge clk);
        check("rst_an", an, 3'b000);
        check("rst_seg", seg, 7'b0);
        check("rst_frame_done", fd, 1'b0);
        restart();

        // Frame 0 with 000, inputs change to 123 mid-frame, frame 1 shows 123
        for (int i = 0; i < 6; i++) cycle(4'd0, 4'd0, 4'd0);
        while (t < 24) cycle(4'd3, 4'd2, 4'd1);

        // Leading-zero patterns and an invalid code, two frames each
        for (int i = 0; i < 24; i++) cycle(4'd7, 4'd0, 4'd0);
        for (int i = 0; i < 24; i++) cycle(4'd0, 4'd7, 4'd0);
        for (int i = 0; i < 24; i++) cycle(4'd0, 4'd0, 4'd1);
        for (int i = 0; i < 24; i++) cycle(4'd12, 4'd4, 4'd8);

        // Random digit streams
        u = 4'd12; d = 4'd4; c = 4'd8;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                u = rand_digit();
                d = rand_digit();
                c = rand_digit();
            end
            cycle(u, d, c);
        end

        // Asynchronous reset in the middle of a tens show slot
        while (t % 24 != 18) cycle(4'd5, 4'd5, 4'd5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", an, 3'b000);
        check("async_rst_seg", seg, 7'b0);
        check("async_rst_frame_done", fd, 1'b0);
        restart();
        for (int i = 0; i < 36; i++) cycle(4'd5, 4'd5, 4'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
